// File: rtl/kgp_ctrl_pkg.sv
// Shared types for the KGP-RISC multi-cycle controller: FSM states, decoded
// instruction classes, opcode class codes and memory function codes.
package kgp_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH
    } cls_e;

    localparam logic [2:0] OPC_ALU_R = 3'b000;
    localparam logic [2:0] OPC_ALU_I = 3'b001;
    localparam logic [2:0] OPC_SHIFT = 3'b010;
    localparam logic [2:0] OPC_MEM   = 3'b011;
    localparam logic [2:0] OPC_JMP   = 3'b100;
    localparam logic [2:0] OPC_BRC   = 3'b101;

    localparam logic [3:0] FUNC_LOAD  = 4'd0;
    localparam logic [3:0] FUNC_STORE = 4'd1;

    // ALU classes encode the operation as {opcode LSB, low three func bits}.
    function automatic logic [3:0] alu_code(input logic opc_lsb, input logic [2:0] func);
        return {opc_lsb, func};
    endfunction

endpackage

// File: rtl/kgp_multicycle_ctrl_if.sv
// Instruction handshake, memory-ready and datapath strobe bundle between the
// fetch unit / datapath (master) and the multi-cycle controller (slave).
interface kgp_multicycle_ctrl_if #(
    parameter int OPC_W   = 3,
    parameter int FUNC_W  = 4,
    parameter int ALUOP_W = 4,
    parameter int BROP_W  = 4
) ();

    logic               instr_valid;
    logic               instr_ready;
    logic [OPC_W-1:0]   opcode;
    logic [FUNC_W-1:0]  funccode;
    logic               mem_ready;
    logic               RegWrite;
    logic               MemToRead;
    logic               MemToReg;
    logic               MemWrite;
    logic [BROP_W-1:0]  BranchOp;
    logic [ALUOP_W-1:0] ALUop;
    logic               done;
    logic               err;

    modport master (
        output instr_valid, opcode, funccode, mem_ready,
        input  instr_ready, RegWrite, MemToRead, MemToReg, MemWrite,
               BranchOp, ALUop, done, err
    );

    modport slave (
        input  instr_valid, opcode, funccode, mem_ready,
        output instr_ready, RegWrite, MemToRead, MemToReg, MemWrite,
               BranchOp, ALUop, done, err
    );

endinterface

// File: rtl/kgp_ctrl_decode.sv
// Combinational instruction classifier: opcode/funccode -> class, ALUop,
// BranchOp and legality.
module kgp_ctrl_decode
    import kgp_ctrl_pkg::*;
#(
    parameter int OPC_W   = 3,
    parameter int FUNC_W  = 4,
    parameter int ALUOP_W = 4,
    parameter int BROP_W  = 4
) (
    input  logic [OPC_W-1:0]   opcode,
    input  logic [FUNC_W-1:0]  funccode,
    output cls_e               cls,
    output logic               legal,
    output logic [ALUOP_W-1:0] aluop,
    output logic [BROP_W-1:0]  brop
);

    always_comb begin
        cls   = CLS_NONE;
        legal = 1'b0;
        aluop = ALUOP_W'(alu_code(opcode[0], funccode[2:0]));
        brop  = BROP_W'(funccode);
        case (opcode)
            OPC_W'(OPC_ALU_R): begin
                legal = (funccode <= FUNC_W'(6));
                cls   = legal ? CLS_ALU : CLS_NONE;
            end
            OPC_W'(OPC_ALU_I): begin
                legal = (funccode >= FUNC_W'(1)) && (funccode <= FUNC_W'(5));
                cls   = legal ? CLS_ALU : CLS_NONE;
            end
            OPC_W'(OPC_SHIFT): begin
                legal = (funccode <= FUNC_W'(1));
                cls   = legal ? CLS_ALU : CLS_NONE;
            end
            OPC_W'(OPC_MEM): begin
                if (funccode == FUNC_W'(FUNC_LOAD)) begin
                    legal = 1'b1;
                    cls   = CLS_LOAD;
                end else if (funccode == FUNC_W'(FUNC_STORE)) begin
                    legal = 1'b1;
                    cls   = CLS_STORE;
                end
            end
            OPC_W'(OPC_JMP), OPC_W'(OPC_BRC): begin
                legal = 1'b1;
                cls   = CLS_BRANCH;
            end
            default: begin
                legal = 1'b0;
                cls   = CLS_NONE;
            end
        endcase
    end

endmodule

// File: rtl/kgp_multicycle_ctrl.sv
// KGP-RISC multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// registered strobes, memory-wait timeout and HALT. Macro: ILLEGAL_TRAP_EN.
module kgp_multicycle_ctrl
    import kgp_ctrl_pkg::*;
#(
    parameter int OPC_W   = 3,
    parameter int FUNC_W  = 4,
    parameter int ALUOP_W = 4,
    parameter int BROP_W  = 4,
    parameter int MEM_TMO = 15
) (
    input logic                 clk,
    input logic                 reset,
    kgp_multicycle_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(MEM_TMO + 1);

    state_e             state_q, state_d;
    logic [OPC_W-1:0]   opcode_q, opcode_d;
    logic [FUNC_W-1:0]  funccode_q, funccode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               instr_ready_q, instr_ready_d;
    logic               reg_write_q, reg_write_d;
    logic               mem_to_read_q, mem_to_read_d;
    logic               mem_to_reg_q, mem_to_reg_d;
    logic               mem_write_q, mem_write_d;
    logic [BROP_W-1:0]  br_op_q, br_op_d;
    logic [ALUOP_W-1:0] alu_op_q, alu_op_d;

    cls_e               dec_cls;
    logic               dec_legal;
    logic [ALUOP_W-1:0] dec_aluop;
    logic [BROP_W-1:0]  dec_brop;

    kgp_ctrl_decode #(
        .OPC_W   (OPC_W),
        .FUNC_W  (FUNC_W),
        .ALUOP_W (ALUOP_W),
        .BROP_W  (BROP_W)
    ) u_decode (
        .opcode   (opcode_q),
        .funccode (funccode_q),
        .cls      (dec_cls),
        .legal    (dec_legal),
        .aluop    (dec_aluop),
        .brop     (dec_brop)
    );

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        funccode_d = funccode_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        done_d     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (bus.instr_valid) begin
                    opcode_d   = bus.opcode;
                    funccode_d = bus.funccode;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    state_d = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    err_d   = 1'b1;
                    state_d = S_HALT;
`else
                    done_d  = 1'b1;
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                case (dec_cls)
                    CLS_ALU:    state_d = S_WB;
                    CLS_BRANCH: begin
                        done_d  = 1'b1;
                        state_d = S_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        cnt_d   = '0;
                        state_d = S_MEM;
                    end
                    default:    state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                // A ready on the final allowed wait cycle still completes the access.
                if (bus.mem_ready) begin
                    cnt_d = '0;
                    if (dec_cls == CLS_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (cnt_q == CNT_W'(MEM_TMO)) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                done_d  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are decoded from the next state so they line up with state_q.
    always_comb begin
        instr_ready_d = (state_d == S_FETCH);
        reg_write_d   = (state_d == S_WB);
        mem_to_reg_d  = (state_d == S_WB)  && (dec_cls == CLS_LOAD);
        mem_to_read_d = (state_d == S_MEM) && (dec_cls == CLS_LOAD);
        mem_write_d   = (state_d == S_MEM) && (dec_cls == CLS_STORE);
        alu_op_d      = ((state_d == S_EXEC) && (dec_cls == CLS_ALU))    ? dec_aluop : '0;
        br_op_d       = ((state_d == S_EXEC) && (dec_cls == CLS_BRANCH)) ? dec_brop  : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            opcode_q      <= '0;
            funccode_q    <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            instr_ready_q <= 1'b1;
            reg_write_q   <= 1'b0;
            mem_to_read_q <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            mem_write_q   <= 1'b0;
            br_op_q       <= '0;
            alu_op_q      <= '0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            funccode_q    <= funccode_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            done_q        <= done_d;
            instr_ready_q <= instr_ready_d;
            reg_write_q   <= reg_write_d;
            mem_to_read_q <= mem_to_read_d;
            mem_to_reg_q  <= mem_to_reg_d;
            mem_write_q   <= mem_write_d;
            br_op_q       <= br_op_d;
            alu_op_q      <= alu_op_d;
        end
    end

    assign bus.instr_ready = instr_ready_q;
    assign bus.RegWrite    = reg_write_q;
    assign bus.MemToRead   = mem_to_read_q;
    assign bus.MemToReg    = mem_to_reg_q;
    assign bus.MemWrite    = mem_write_q;
    assign bus.BranchOp    = br_op_q;
    assign bus.ALUop       = alu_op_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_kgp_multicycle_ctrl.sv
// Directed scoreboard bench for kgp_multicycle_ctrl; honours ILLEGAL_TRAP_EN
// when the design is built with it.
module tb_kgp_multicycle_ctrl;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct packed {
        logic       rdy;
        logic       rw;
        logic       mtr;
        logic       mtreg;
        logic       mw;
        logic [3:0] brop;
        logic [3:0] aluop;
        logic       done;
        logic       err;
    } obs_t;

    typedef struct packed {
        obs_t exp;
        logic mr;
    } step_t;

    logic   clk = 1'b0;
    logic   reset;
    obs_t   obs;
    step_t  sbq[$];
    int     n_assert = 0;
    int     n_fail   = 0;

    always #5 clk = ~clk;

    kgp_multicycle_ctrl_if #(.OPC_W(3), .FUNC_W(4), .ALUOP_W(4), .BROP_W(4)) bus ();

    kgp_multicycle_ctrl #(
        .OPC_W   (3),
        .FUNC_W  (4),
        .ALUOP_W (4),
        .BROP_W  (4),
        .MEM_TMO (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always_comb obs = {bus.instr_ready, bus.RegWrite, bus.MemToRead, bus.MemToReg,
                       bus.MemWrite, bus.BranchOp, bus.ALUop, bus.done, bus.err};

    function automatic obs_t mk(input logic rdy, input logic rw, input logic mtr,
                                input logic mtreg, input logic mw, input logic [3:0] brop,
                                input logic [3:0] aluop, input logic done, input logic err);
        return {rdy, rw, mtr, mtreg, mw, brop, aluop, done, err};
    endfunction

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input obs_t e, input logic mr);
        step_t s;
        s.exp = e;
        s.mr  = mr;
        sbq.push_back(s);
    endtask

    // Expected post-edge output vectors for one instruction accepted from FETCH.
    // waits < 0 means memory never answers.
    task automatic model(input logic [2:0] op, input logic [3:0] fn, input int waits,
                         output bit halted);
        int kind; // 0 illegal, 1 alu, 2 load, 3 store, 4 branch
        int n;
        halted = 1'b0;
        case (op)
            3'd0:       kind = (fn <= 4'd6) ? 1 : 0;
            3'd1:       kind = (fn >= 4'd1 && fn <= 4'd5) ? 1 : 0;
            3'd2:       kind = (fn <= 4'd1) ? 1 : 0;
            3'd3:       kind = (fn == 4'd0) ? 2 : ((fn == 4'd1) ? 3 : 0);
            3'd4, 3'd5: kind = 4;
            default:    kind = 0;
        endcase
        push(mk(L, L, L, L, L, 4'h0, 4'h0, L, L), L);
        case (kind)
            0: begin
`ifdef ILLEGAL_TRAP_EN
                push(mk(L, L, L, L, L, 4'h0, 4'h0, L, H), L);
                push(mk(L, L, L, L, L, 4'h0, 4'h0, L, H), L);
                halted = 1'b1;
`else
                push(mk(H, L, L, L, L, 4'h0, 4'h0, H, L), L);
`endif
            end
            1: begin
                push(mk(L, L, L, L, L, 4'h0, {op[0], fn[2:0]}, L, L), L);
                push(mk(L, H, L, L, L, 4'h0, 4'h0, L, L), L);
                push(mk(H, L, L, L, L, 4'h0, 4'h0, H, L), L);
            end
            4: begin
                push(mk(L, L, L, L, L, fn, 4'h0, L, L), L);
                push(mk(H, L, L, L, L, 4'h0, 4'h0, H, L), L);
            end
            default: begin
                push(mk(L, L, L, L, L, 4'h0, 4'h0, L, L), L);
                n = (waits < 0) ? 16 : waits + 1;
                for (int i = 0; i < n; i++)
                    push(mk(L, L, kind == 2, L, kind == 3, 4'h0, 4'h0, L, L), i == waits);
                if (waits < 0) begin
                    push(mk(L, L, L, L, L, 4'h0, 4'h0, L, H), L);
                    push(mk(L, L, L, L, L, 4'h0, 4'h0, L, H), L);
                    halted = 1'b1;
                end else if (kind == 2) begin
                    push(mk(L, H, L, H, L, 4'h0, 4'h0, L, L), L);
                    push(mk(H, L, L, L, L, 4'h0, 4'h0, H, L), L);
                end else begin
                    push(mk(H, L, L, L, L, 4'h0, 4'h0, H, L), L);
                end
            end
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        check("reset_hold", obs, mk(H, L, L, L, L, 4'h0, 4'h0, L, L));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_release", obs, mk(H, L, L, L, L, 4'h0, 4'h0, L, L));
    endtask

    // Called at a negedge with the DUT idle in FETCH.
    task automatic issue(input string tag, input logic [2:0] op, input logic [3:0] fn,
                         input int waits, input bit scramble);
        bit    halted;
        step_t s;
        int    idx = 0;
        model(op, fn, waits, halted);
        bus.instr_valid = 1'b1;
        bus.opcode      = op;
        bus.funccode    = fn;
        bus.mem_ready   = 1'b0;
        while (sbq.size() > 0) begin
            @(negedge clk);
            if (scramble) begin
                bus.opcode   = 3'($urandom);
                bus.funccode = 4'($urandom);
            end else begin
                bus.instr_valid = 1'b0;
            end
            s = sbq.pop_front();
            check($sformatf("%s[%0d]", tag, idx), obs, s.exp);
            bus.mem_ready = s.mr;
            idx++;
        end
        bus.instr_valid = 1'b0;
        bus.mem_ready   = 1'b0;
        if (halted) do_reset();
    endtask

    initial begin
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.opcode      = '0;
        bus.funccode    = '0;
        bus.mem_ready   = 1'b0;
        do_reset();

        issue("alu_reg",   3'b000, 4'b0010, 0, 1'b0);
        issue("alu_imm",   3'b001, 4'b0101, 0, 1'b0);
        issue("shift_hv",  3'b010, 4'b0001, 0, 1'b1);
        issue("brc",       3'b101, 4'b0110, 0, 1'b0);
        issue("jmp",       3'b100, 4'b1111, 0, 1'b0);
        issue("load_w3",   3'b011, 4'b0000, 3, 1'b0);
        issue("store_w0",  3'b011, 4'b0001, 0, 1'b0);
        issue("load_w15",  3'b011, 4'b0000, 15, 1'b0);
        issue("ill_opc",   3'b111, 4'b0000, 0, 1'b0);
        issue("ill_mem",   3'b011, 4'b0010, 0, 1'b0);
        issue("ill_alu",   3'b000, 4'b0111, 0, 1'b0);
        issue("store_tmo", 3'b011, 4'b0001, -1, 1'b0);

        // Asynchronous reset while a store is waiting in MEM.
        bus.instr_valid = 1'b1;
        bus.opcode      = 3'b011;
        bus.funccode    = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
        end
        check("abort_pre", obs, mk(L, L, L, L, H, 4'h0, 4'h0, L, L));
        #2 reset = 1'b1;
        #1 check("abort_async", obs, mk(H, L, L, L, L, 4'h0, 4'h0, L, L));
        @(negedge clk);
        reset = 1'b0;
        issue("after_abort", 3'b000, 4'b0110, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
